// File: rtl/tcam_add_if.sv
// Signal bundle between tcam_add_sched and its environment: table load,
// two operand requesters, the external adder and the response strobes.
interface tcam_add_if;
   logic        cfg_start, cfg_valid, cfg_ready;
   logic [4:0]  cfg_wdata;
   logic        tbl_we;
   logic [6:0]  tbl_addr;
   logic [4:0]  tbl_wdata;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic [63:0] add_a, add_b;
   logic [64:0] add_sum;
   logic        rsp0_valid, rsp1_valid;
   logic [64:0] rsp_sum;
   logic        tbl_loaded, busy, err;

   modport slave (
      input  cfg_start, cfg_valid, cfg_wdata, req0_valid, req0_a, req0_b,
             req1_valid, req1_a, req1_b, add_sum,
      output cfg_ready, tbl_we, tbl_addr, tbl_wdata, req0_ready, req1_ready,
             add_a, add_b, rsp0_valid, rsp1_valid, rsp_sum, tbl_loaded, busy, err
   );
   modport master (
      output cfg_start, cfg_valid, cfg_wdata, req0_valid, req0_a, req0_b,
             req1_valid, req1_a, req1_b, add_sum,
      input  cfg_ready, tbl_we, tbl_addr, tbl_wdata, req0_ready, req1_ready,
             add_a, add_b, rsp0_valid, rsp1_valid, rsp_sum, tbl_loaded, busy, err
   );
endinterface

// File: rtl/tcam_add_sched.sv
// Scheduler for a fixed-latency TCAM adder: loads its lookup tables, then
// round-robins two requesters into the adder. TCAM_ADD_CHECK_EN adds a golden-sum checker.
module tcam_add_sched #(
   parameter int LAT       = 16,
   parameter int TBL_DEPTH = 128
) (
   input logic      clk,
   input logic      rst,
   tcam_add_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   state_t       state, state_nxt;
   logic [6:0]   idx;
   logic [6:0]   inflight;
   logic         last_gnt;
   logic         gnt0, gnt1, grant, cfg_fire, last_word, retire, drained;
   logic [63:0]  win_a, win_b;
   // bit 0 lines up with the registered operands; bit LAT with a valid add_sum
   logic [LAT:0] vld_pipe, tag_pipe;

   assign cfg_fire  = (state == LOAD) && bus.cfg_valid;
   assign last_word = cfg_fire && (idx == 7'(TBL_DEPTH - 1));
   assign retire    = vld_pipe[LAT];
   assign drained   = (state == DRAIN) && (inflight == 7'd0);
   assign grant     = gnt0 | gnt1;
   assign win_a     = gnt1 ? bus.req1_a : bus.req0_a;
   assign win_b     = gnt1 ? bus.req1_b : bus.req0_b;
   assign bus.tbl_addr = idx;
   assign bus.busy     = (state == LOAD) || (state == DRAIN) || (inflight != 7'd0);

   always_comb begin
      state_nxt      = state;
      gnt0           = 1'b0;
      gnt1           = 1'b0;
      bus.cfg_ready  = 1'b0;
      bus.tbl_we     = 1'b0;
      bus.tbl_wdata  = 5'd0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      unique case (state)
         IDLE: if (bus.cfg_start) state_nxt = LOAD;
         LOAD: begin
            bus.cfg_ready = 1'b1;
            bus.tbl_we    = bus.cfg_valid;
            bus.tbl_wdata = bus.cfg_valid ? bus.cfg_wdata : 5'd0;
            if (last_word) state_nxt = RUN;
         end
         RUN: begin
            // last_gnt=1 means requester 1 won last, so requester 0 is favoured
            if (bus.req0_valid && bus.req1_valid) begin
               gnt0 = last_gnt;
               gnt1 = !last_gnt;
            end else begin
               gnt0 = bus.req0_valid;
               gnt1 = bus.req1_valid;
            end
            bus.req0_ready = gnt0;
            bus.req1_ready = gnt1;
            if (bus.cfg_start) state_nxt = DRAIN;
         end
         DRAIN: if (drained) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= 7'd0;
         inflight       <= 7'd0;
         last_gnt       <= 1'b1;
         vld_pipe       <= '0;
         tag_pipe       <= '0;
         bus.tbl_loaded <= 1'b0;
         bus.add_a      <= 64'd0;
         bus.add_b      <= 64'd0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp_sum    <= 65'd0;
      end else begin
         state <= state_nxt;
         if (cfg_fire) idx <= last_word ? 7'd0 : idx + 7'd1;
         if (last_word) bus.tbl_loaded <= 1'b1;
         else if (drained) begin
            bus.tbl_loaded <= 1'b0;
            idx            <= 7'd0;
         end
         if (grant) begin
            last_gnt  <= gnt1;
            bus.add_a <= win_a;
            bus.add_b <= win_b;
         end
         vld_pipe       <= {vld_pipe[LAT-1:0], grant};
         tag_pipe       <= {tag_pipe[LAT-1:0], gnt1};
         inflight       <= inflight + 7'(grant) - 7'(retire);
         bus.rsp0_valid <= retire && !tag_pipe[LAT];
         bus.rsp1_valid <= retire && tag_pipe[LAT];
         if (retire) bus.rsp_sum <= bus.add_sum;
      end
   end

`ifdef TCAM_ADD_CHECK_EN
   logic [LAT:0][64:0] gold;
   logic               err_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gold  <= '0;
         err_r <= 1'b0;
      end else begin
         gold <= {gold[LAT-1:0], {1'b0, win_a} + {1'b0, win_b}};
         if (retire && (gold[LAT] != bus.add_sum)) err_r <= 1'b1;
      end
   end
   assign bus.err = err_r;
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_tcam_add_sched.sv
// Directed bench for tcam_add_sched: a fixed-latency adder model, a response
// scoreboard filled at grant time and drained by an independent monitor.
module tb_tcam_add_sched;
   localparam int LAT = 16;
`ifdef TCAM_ADD_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   typedef struct {
      logic        owner;
      logic [64:0] sum;
      int          gcyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bump = 1'b0;
   int   cyc = 0;
   int   we_cnt = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   logic [64:0] apipe [LAT];

   tcam_add_if bus ();
   tcam_add_sched #(.LAT(LAT), .TBL_DEPTH(128)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bus.tbl_we) we_cnt <= we_cnt + 1;

   // adder: operands seen on add_a/add_b appear on add_sum LAT cycles later
   always @(posedge clk) begin
      apipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + 65'(bump);
      for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
   end
   assign bus.add_sum = apipe[LAT-1];

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out", nm);
   endtask

   always @(negedge clk) begin
      if (!rst && (bus.rsp0_valid || bus.rsp1_valid)) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: got rsp0=%b rsp1=%b want none", bus.rsp0_valid, bus.rsp1_valid);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_one_hot", 65'(bus.rsp0_valid & bus.rsp1_valid), 65'd0);
            chk("rsp_owner", 65'(bus.rsp1_valid), 65'(e.owner));
            chk("rsp_sum", bus.rsp_sum, e.sum);
            chk("rsp_latency", 65'(cyc - e.gcyc), 65'(LAT + 1));
         end
      end
   end

   task automatic cfg_pulse();
      bus.cfg_start = 1'b1;
      @(posedge clk); #1;
      bus.cfg_start = 1'b0;
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) begin
         bus.cfg_valid = 1'b1;
         bus.cfg_wdata = 5'(i % 32);
         @(negedge clk);
         chk("load_we", 65'(bus.tbl_we), 65'd1);
         chk("load_addr", 65'(bus.tbl_addr), 65'(i));
         chk("load_wdata", 65'(bus.tbl_wdata), 65'(i % 32));
         @(posedge clk); #1;
      end
      bus.cfg_valid = 1'b0;
   endtask

   // one cycle of requests; the expected winner comes from the caller's table
   task automatic issue(input logic v0, input logic v1, input logic [63:0] a0, input logic [63:0] b0,
                        input logic [63:0] a1, input logic [63:0] b1, input logic owner, input logic corrupt);
      exp_t e;
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
      @(negedge clk);
      chk("grant_req0", 65'(bus.req0_ready), 65'(!owner));
      chk("grant_req1", 65'(bus.req1_ready), 65'(owner));
      e.owner = owner;
      e.sum   = owner ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
      if (corrupt) e.sum = e.sum + 65'd1;
      e.gcyc  = cyc + 1;
      q.push_back(e);
      @(posedge clk); #1;
      if (corrupt) begin
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
         bump = 1'b1;
         @(posedge clk); #1;
         bump = 1'b0;
      end
   endtask

   task automatic wait_empty(input string nm);
      int t;
      t = 0;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (q.size() != 0) timeout(nm);
   endtask

   initial begin
      bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_wdata = 0;
      bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
      bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tbl_loaded", 65'(bus.tbl_loaded), 65'd0);
      chk("rst_err", 65'(bus.err), 65'd0);
      chk("rst_add_a", 65'(bus.add_a), 65'd0);
      chk("rst_add_b", 65'(bus.add_b), 65'd0);
      chk("rst_rsp_sum", bus.rsp_sum, 65'd0);
      chk("rst_busy", 65'(bus.busy), 65'd0);
      chk("rst_cfg_ready", 65'(bus.cfg_ready), 65'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // full table load
      cfg_pulse();
      we_cnt = 0;
      load_words(128);
      @(negedge clk);
      chk("load_we_count", 65'(we_cnt), 65'd128);
      chk("load_tbl_loaded", 65'(bus.tbl_loaded), 65'd1);
      chk("run_addr_wrap", 65'(bus.tbl_addr), 65'd0);
      chk("run_cfg_ready", 65'(bus.cfg_ready), 65'd0);
      chk("run_busy_idle", 65'(bus.busy), 65'd0);
      @(posedge clk); #1;

      // both requesters valid for six cycles: alternate starting with 0
      for (int i = 0; i < 6; i++)
         issue(1'b1, 1'b1, 64'h100 + 64'(i), 64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20 + 64'(i),
               logic'(i % 2), 1'b0);
      bus.req0_valid = 0; bus.req1_valid = 0;
      @(negedge clk);
      chk("busy_inflight", 65'(bus.busy), 65'd1);
      wait_empty("rr_drain");

      // carry-out case
      issue(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 1'b0, 1'b0);
      bus.req0_valid = 0;
      wait_empty("carry_rsp");

      // five ops on requester 1, cfg_start together with the fifth grant
      for (int i = 0; i < 5; i++) begin
         bus.cfg_start = (i == 4);
         issue(1'b0, 1'b1, 64'h0, 64'h0, 64'h1000 * 64'(i + 1), 64'(7 * i), 1'b1, 1'b0);
      end
      bus.cfg_start = 0;
      bus.req0_valid = 1; bus.req1_valid = 1;
      begin
         int t;
         t = 0;
         @(negedge clk);
         while (!bus.cfg_ready && t < 60) begin
            chk("drain_no_ready", 65'(bus.req0_ready | bus.req1_ready), 65'd0);
            @(negedge clk);
            t++;
         end
         if (!bus.cfg_ready) timeout("drain_to_load");
      end
      bus.req0_valid = 0; bus.req1_valid = 0;
      chk("drain_all_rsp", 65'(q.size()), 65'd0);
      chk("drain_tbl_loaded", 65'(bus.tbl_loaded), 65'd0);
      chk("drain_addr", 65'(bus.tbl_addr), 65'd0);
      @(posedge clk); #1;

      // reset in the middle of a reload
      load_words(40);
      rst = 1'b1;
      #1;
      chk("midrst_cfg_ready", 65'(bus.cfg_ready), 65'd0);
      chk("midrst_busy", 65'(bus.busy), 65'd0);
      chk("midrst_addr", 65'(bus.tbl_addr), 65'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      cfg_pulse();
      load_words(128);
      @(negedge clk);
      chk("reload_tbl_loaded", 65'(bus.tbl_loaded), 65'd1);
      @(posedge clk); #1;

      // adder returns a wrong sum once
      chk("err_before", 65'(bus.err), 65'd0);
      issue(1'b1, 1'b0, 64'h1234, 64'h4321, 64'h0, 64'h0, 1'b0, 1'b1);
      wait_empty("bad_rsp");
      @(negedge clk);
      chk("err_after_bad", 65'(bus.err), 65'(EXP_ERR));
      @(posedge clk); #1;
      issue(1'b0, 1'b1, 64'h0, 64'h0, 64'h55, 64'hAA, 1'b1, 1'b0);
      bus.req1_valid = 0;
      wait_empty("good_rsp");
      @(negedge clk);
      chk("err_sticky", 65'(bus.err), 65'(EXP_ERR));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
